// File: rtl/bird_motion.sv
// Vertical-motion engine for the player bird: signed-velocity physics, game-phase FSM,
// edge-detected flaps, ceiling/floor clamping and a collision-driven death fall.
module bird_motion #(
    parameter int Y_W     = 10,
    parameter int V_W     = 6,
    parameter int Y_START = 240,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 460,
    parameter int JUMP_V  = -8,
    parameter int V_MAX   = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           tick,
    input  logic           jump,
    input  logic           start,
    input  logic           hit,
    input  logic [1:0]     fall_accel,
    output logic [Y_W-1:0] y_coord,
    output logic [V_W-1:0] velocity,
    output logic [1:0]     phase,
    output logic           dead,
    output logic           flap
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FLY      = 2'b01,
        DYING    = 2'b10,
        GROUNDED = 2'b11
    } phase_t;

    localparam logic [Y_W-1:0]        Y_START_L = Y_START[Y_W-1:0];
    localparam logic [Y_W-1:0]        Y_MIN_L   = Y_MIN[Y_W-1:0];
    localparam logic [Y_W-1:0]        Y_MAX_L   = Y_MAX[Y_W-1:0];
    localparam logic signed [Y_W+1:0] Y_MIN_W   = Y_MIN[Y_W+1:0];
    localparam logic signed [Y_W+1:0] Y_MAX_W   = Y_MAX[Y_W+1:0];
    localparam logic signed [V_W-1:0] JUMP_V_L  = JUMP_V[V_W-1:0];
    localparam logic signed [V_W:0]   V_MAX_W   = V_MAX[V_W:0];

    phase_t                phase_q, phase_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic signed [V_W-1:0] v_q, v_d;
    logic                  dead_q, dead_d;
    logic                  flap_q, flap_d;
    logic                  flap_req_q, flap_req_d;
    logic                  jump_prev_q, jump_prev_d;

    logic                  jump_edge;
    logic                  use_flap;
    logic signed [V_W:0]   v_wide;
    logic signed [V_W-1:0] v_grav;
    logic signed [V_W-1:0] v_next;
    logic signed [Y_W+1:0] y_sum;

    // Gravity is saturated before the position add so the velocity can never wrap.
    always_comb begin
        jump_edge = jump & ~jump_prev_q;
        use_flap  = (phase_q == FLY) && flap_req_q;
        v_wide    = $signed({v_q[V_W-1], v_q}) + $signed({{(V_W-1){1'b0}}, fall_accel});
        v_grav    = (v_wide > V_MAX_W) ? V_MAX_W[V_W-1:0] : v_wide[V_W-1:0];
        v_next    = use_flap ? JUMP_V_L : v_grav;
        y_sum     = $signed({2'b00, y_q}) + $signed({{(Y_W+2-V_W){v_next[V_W-1]}}, v_next});
    end

    always_comb begin
        jump_prev_d = jump;
        phase_d     = phase_q;
        y_d         = y_q;
        v_d         = v_q;
        flap_d      = 1'b0;
        flap_req_d  = flap_req_q | jump_edge;

        if (!enable) begin
            flap_req_d = 1'b0;
        end else begin
            unique case (phase_q)
                IDLE: begin
                    y_d = Y_START_L;
                    v_d = '0;
                    if (start || flap_req_q) begin
                        phase_d    = FLY;
                        v_d        = JUMP_V_L;
                        flap_d     = 1'b1;
                        flap_req_d = jump_edge;
                    end
                end
                FLY, DYING: begin
                    if (phase_q == DYING) begin
                        flap_req_d = 1'b0;
                    end
                    if (phase_q == FLY && hit) begin
                        phase_d    = DYING;
                        flap_req_d = 1'b0;
                    end else if (tick) begin
                        if (use_flap) begin
                            flap_d     = 1'b1;
                            flap_req_d = jump_edge;
                        end
                        if (y_sum <= Y_MIN_W) begin
                            y_d = Y_MIN_L;
                            v_d = '0;
                        end else if (y_sum >= Y_MAX_W) begin
                            y_d     = Y_MAX_L;
                            v_d     = '0;
                            phase_d = GROUNDED;
                        end else begin
                            y_d = y_sum[Y_W-1:0];
                            v_d = v_next;
                        end
                    end
                end
                GROUNDED: begin
                    flap_req_d = 1'b0;
                    if (start) begin
                        phase_d = IDLE;
                        y_d     = Y_START_L;
                        v_d     = '0;
                    end
                end
                default: begin
                    phase_d = IDLE;
                end
            endcase
        end

        dead_d = (phase_d == DYING) || (phase_d == GROUNDED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q     <= IDLE;
            y_q         <= Y_START_L;
            v_q         <= '0;
            dead_q      <= 1'b0;
            flap_q      <= 1'b0;
            flap_req_q  <= 1'b0;
            jump_prev_q <= 1'b0;
        end else begin
            jump_prev_q <= jump_prev_d;
            flap_req_q  <= flap_req_d;
            flap_q      <= flap_d;
            if (enable) begin
                phase_q <= phase_d;
                y_q     <= y_d;
                v_q     <= v_d;
                dead_q  <= dead_d;
            end
        end
    end

    assign y_coord  = y_q;
    assign velocity = v_q;
    assign phase    = phase_q;
    assign dead     = dead_q;
    assign flap     = flap_q;

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion: flight, flaps, ceiling, floor, death fall, pause and
// asynchronous reset, with hand-computed expected rows/velocities.
module tb_bird_motion;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       tick;
    logic       jump;
    logic       start;
    logic       hit;
    logic [1:0] fall_accel;
    logic [9:0] y_coord;
    logic [5:0] velocity;
    logic [1:0] phase;
    logic       dead;
    logic       flap;

    int tests_run;
    int tests_failed;

    bird_motion dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .tick       (tick),
        .jump       (jump),
        .start      (start),
        .hit        (hit),
        .fall_accel (fall_accel),
        .y_coord    (y_coord),
        .velocity   (velocity),
        .phase      (phase),
        .dead       (dead),
        .flap       (flap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Phase implies dead: high only in DYING (2) and GROUNDED (3).
    task automatic check_output(input string tag, input int y, input int v,
                                input int ph, input int fl);
        check({tag, "/y"}, y_coord, y);
        check({tag, "/v"}, $signed(velocity), v);
        check({tag, "/phase"}, phase, ph);
        check({tag, "/dead"}, dead, (ph >= 2) ? 1 : 0);
        check({tag, "/flap"}, flap, fl);
    endtask

    // One clock cycle with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic apply_stimulus(input logic t, input logic s, input logic j,
                                  input logic h, input logic [1:0] acc);
        tick       = t;
        start      = s;
        jump       = j;
        hit        = h;
        fall_accel = acc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        enable       = 1'b1;
        tick         = 1'b0;
        jump         = 1'b0;
        start        = 1'b0;
        hit          = 1'b0;
        fall_accel   = 2'd0;

        #3 rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("reset", 240, 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 0, 1);
        check_output("idle_ticks", 240, 0, 0, 0);

        apply_stimulus(0, 1, 0, 0, 1);
        check_output("start", 240, -8, 1, 1);
        apply_stimulus(1, 0, 0, 0, 0);
        check_output("fly_t0", 232, -8, 1, 0);
        apply_stimulus(1, 0, 0, 0, 1);
        check_output("fly_t1", 225, -7, 1, 0);
        apply_stimulus(1, 0, 0, 0, 1);
        check_output("fly_t2", 219, -6, 1, 0);

        // Fall from 219 with accel 3: -3,0,3,6,9,12 then saturated at 12.
        for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 0, 0, 3);
        check_output("sat", 246, 12, 1, 0);
        for (int i = 0; i < 17; i++) apply_stimulus(1, 0, 0, 0, 3);
        check_output("near_floor", 450, 12, 1, 0);
        apply_stimulus(1, 0, 0, 0, 3);
        check_output("floor", 460, 0, 3, 0);
        apply_stimulus(1, 0, 0, 1, 3);
        apply_stimulus(1, 0, 0, 0, 3);
        check_output("grounded_hold", 460, 0, 3, 0);

        apply_stimulus(0, 1, 0, 0, 0);
        check_output("restart", 240, 0, 0, 0);

        apply_stimulus(0, 0, 1, 0, 1);
        check_output("idle_edge", 240, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 1);
        check_output("idle_flap", 240, -8, 1, 1);
        apply_stimulus(1, 0, 1, 0, 1);
        check("held_flap0", flap, 0);
        apply_stimulus(1, 0, 1, 0, 1);
        check("held_flap1", flap, 0);
        apply_stimulus(1, 0, 1, 0, 1);
        check("held_flap2", flap, 0);
        apply_stimulus(1, 0, 1, 0, 1);
        check_output("held_jump", 218, -4, 1, 0);

        apply_stimulus(1, 0, 0, 0, 2);
        check_output("slow", 216, -2, 1, 0);
        for (int i = 0; i < 106; i++) apply_stimulus(1, 0, 0, 0, 0);
        check_output("at_y4", 4, -2, 1, 0);
        apply_stimulus(0, 0, 1, 0, 0);
        check_output("edge_no_tick", 4, -2, 1, 0);
        apply_stimulus(1, 0, 1, 0, 0);
        check_output("ceiling", 0, 0, 1, 1);

        apply_stimulus(1, 0, 0, 0, 1);
        check_output("off_ceiling", 1, 1, 1, 0);
        apply_stimulus(1, 0, 1, 1, 3);
        check_output("hit", 1, 1, 2, 0);
        for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 1, 0, 3);
        check_output("dying_fall", 34, 12, 2, 0);
        apply_stimulus(1, 1, 0, 0, 3);
        check_output("dying_start", 46, 12, 2, 0);
        apply_stimulus(1, 0, 1, 0, 3);
        check_output("dying_jump", 58, 12, 2, 0);
        for (int i = 0; i < 33; i++) apply_stimulus(1, 0, 0, 0, 3);
        check_output("dying_low", 454, 12, 2, 0);
        apply_stimulus(1, 0, 0, 0, 3);
        check_output("dying_floor", 460, 0, 3, 0);
        apply_stimulus(0, 1, 0, 0, 0);
        check_output("respawn", 240, 0, 0, 0);

        apply_stimulus(0, 1, 0, 0, 1);
        check_output("start2", 240, -8, 1, 1);
        apply_stimulus(1, 0, 0, 0, 1);
        check_output("pre_pause", 233, -7, 1, 0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 0, logic'(i % 2), 0, 3);
            check("pause_y", y_coord, 233);
            check("pause_flap", flap, 0);
        end
        check_output("paused", 233, -7, 1, 0);
        enable = 1'b1;
        apply_stimulus(1, 0, 1, 0, 1);
        check_output("resume", 227, -6, 1, 0);
        apply_stimulus(0, 1, 1, 0, 1);
        check_output("fly_start_ign", 227, -6, 1, 0);
        apply_stimulus(1, 0, 1, 0, 1);
        check_output("resume2", 222, -5, 1, 0);

        apply_stimulus(0, 0, 1, 1, 1);
        check_output("hit2", 222, -5, 2, 0);
        apply_stimulus(1, 0, 1, 0, 1);
        check_output("dying2", 218, -4, 2, 0);
        #2 rst = 1'b0;
        #1;
        check_output("async_rst", 240, 0, 0, 0);
        @(posedge clk);
        #3 rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
